fwd_pre: RTL and testbench

FWD_PRE -- requirements
Module: fwd_pre

---
 rtl/fwd_pre.sv | 169 ++++++++++++++++
 tb/tb_fwd_pre.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_pre.sv
// fwd_pre: block-wise forward predictor and symbol mapper.
// Each block starts from a latched reference sample. Every accepted raw
// sample is predicted from the previous one. The prediction error is folded
// into an unsigned DW-bit symbol, and the symbols of a block are gathered into
// a packed buffer that is held until downstream accepts it.
// Optional feature: define FWD_PRE_ZBLK_EN to add the zero_blk output, which
// flags a held block whose symbols are all zero.
module fwd_pre #(
  parameter int DW     = 10,
  parameter int BLKMAX = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           j,
  input  logic [DW-1:0]        xref,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW*BLKMAX-1:0] symbol
`ifdef FWD_PRE_ZBLK_EN
  ,
  output logic                 zero_blk
`endif
);

  localparam int            SW      = DW * BLKMAX;
  localparam logic [5:0]    BLK_LEN = 6'(BLKMAX);
  localparam logic [DW-1:0] MAXV    = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    len_q, len_d;
  logic [5:0]    k_q, k_d;
  logic [DW-1:0] xp_q, xp_d;
  logic [SW-1:0] sym_q, sym_d;

  logic          open_blk;
  logic          accept;
  logic          last_accept;

  logic          neg;
  logic [DW-1:0] mag;
  logic [DW-1:0] theta;
  logic [DW-1:0] mapped;

  // Handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    open_blk    = (state_q == IDLE) && start;
    accept      = (state_q == RUN) && in_valid;
    last_accept = accept && (k_q == (len_q - 6'd1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a block opens on start, fills, then waits for downstream
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_accept) state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: samples flow only in RUN, the block is offered only in HOLD
  always_comb begin
    in_ready  = (state_q == RUN);
    out_valid = (state_q == HOLD);
  end

  // Symbol mapping: the signed error is kept as sign plus magnitude. This
  // keeps every term in DW bits. theta is the distance from the prediction
  // to the nearer range edge. Errors within +/-theta interleave as even
  // (positive) and odd (negative) codes. Larger errors can only point one
  // way, so they continue linearly above 2*theta.
  always_comb begin
    neg   = (x_in < xp_q);
    mag   = neg ? (xp_q - x_in) : (x_in - xp_q);
    theta = (xp_q <= (MAXV - xp_q)) ? xp_q : (MAXV - xp_q);
    if (mag <= theta) begin
      mapped = neg ? ((mag << 1) - DW'(1)) : (mag << 1);
    end else begin
      mapped = theta + mag;
    end
  end

  // Datapath next values: open a block or fold in the accepted sample
  always_comb begin
    len_d = len_q;
    k_d   = k_q;
    xp_d  = xp_q;
    sym_d = sym_q;
    if (open_blk) begin
      len_d = ((j == 6'd0) || (j > BLK_LEN)) ? BLK_LEN : j;
      xp_d  = xref;
      k_d   = 6'd0;
      sym_d = '0;
    end else if (accept) begin
      sym_d[SW-1-DW*int'(k_q) -: DW] = mapped;
      xp_d = x_in;
      k_d  = k_q + 6'd1;
    end
  end

  // Datapath registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= 6'd0;
      k_q   <= 6'd0;
      xp_q  <= '0;
      sym_q <= '0;
    end else begin
      len_q <= len_d;
      k_q   <= k_d;
      xp_q  <= xp_d;
      sym_q <= sym_d;
    end
  end

  // Packed symbol buffer drives the output directly
  always_comb begin
    symbol = sym_q;
  end

`ifdef FWD_PRE_ZBLK_EN
  logic zero_q, zero_d;

  // Running all-zero flag: set when a block opens, cleared by any nonzero symbol
  always_comb begin
    zero_d = zero_q;
    if (open_blk) begin
      zero_d = 1'b1;
    end else if (accept) begin
      zero_d = zero_q && (mapped == '0);
    end
  end

  // All-zero flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  // The flag is only meaningful while a finished block is held
  always_comb begin
    zero_blk = zero_q && (state_q == HOLD);
  end
`endif

endmodule

// File: tb/tb_fwd_pre.sv
// tb_fwd_pre: directed and randomized checks of fwd_pre against a
// reference model of the prediction/mapping rules. Build with
// FWD_PRE_ZBLK_EN defined to also check zero_blk.
module tb_fwd_pre;

  localparam int DW     = 10;
  localparam int BLKMAX = 32;
  localparam int SW     = DW * BLKMAX;
  localparam int MAXV   = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    j = '0;
  logic [DW-1:0] xref = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] symbol;
`ifdef FWD_PRE_ZBLK_EN
  logic          zero_blk;
`endif

  int            checks = 0;
  int            errors = 0;
  int            smp[BLKMAX];
  logic [SW-1:0] exp_sym;
  bit            exp_zero;

  fwd_pre #(.DW(DW), .BLKMAX(BLKMAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .j         (j),
    .xref      (xref),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .symbol    (symbol)
`ifdef FWD_PRE_ZBLK_EN
    ,
    .zero_blk  (zero_blk)
`endif
  );

  always #5 clk = ~clk;

  // Reference mapping computed from the folding rules with plain integers
  function automatic int mapSym(input int xp, input int x);
    int d, th, ad;
    d  = x - xp;
    th = (xp < (MAXV - xp)) ? xp : (MAXV - xp);
    ad = (d < 0) ? -d : d;
    if (d >= 0 && d <= th) return 2 * d;
    else if (d < 0 && ad <= th) return 2 * ad - 1;
    else return th + ad;
  endfunction

  task automatic checkOutput(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) smp[i] = ($urandom_range(0, 1) == 1) ? MAXV : 0;
      else smp[i] = $urandom_range(0, MAXV);
    end
  endtask

  // Opens a block at the current negedge, feeds smp[], checks the result.
  // abort_after >= 0 returns early (still in RUN) after that many accepts.
  task automatic applyStimulus(input int jv, input int xr, input bit toggle,
                               input bit pulse_mid, input int abort_after);
    int len, accepts, cyc, xp, m;
    len      = (jv == 0 || jv > BLKMAX) ? BLKMAX : jv;
    exp_sym  = '0;
    exp_zero = 1'b1;
    xp       = xr;
    for (int i = 0; i < len; i++) begin
      m = mapSym(xp, smp[i]);
      exp_sym[SW-1-DW*i -: DW] = DW'(m);
      if (m != 0) exp_zero = 1'b0;
      xp = smp[i];
    end
    start    = 1'b1;
    j        = 6'(jv);
    xref     = DW'(xr);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    j     = 6'($urandom);
    xref  = DW'($urandom);
    accepts = 0;
    cyc     = 0;
    while (accepts < len && cyc < 4 * BLKMAX + 8) begin
      if (abort_after >= 0 && accepts == abort_after) return;
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      x_in     = in_valid ? DW'(smp[accepts]) : DW'($urandom);
      start    = pulse_mid && (cyc == 1);
      checkOutput("run_out_valid_low", out_valid, 0);
      if (in_valid && in_ready) accepts++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("accept_count", accepts, len);
    if (toggle) checkOutput("toggle_cycles", cyc, 2 * len - 1);
    else checkOutput("no_bubbles", cyc, len);
    checkOutput("out_valid_rise", out_valid, 1);
    checkOutput("in_ready_hold", in_ready, 0);
    checkOutput("symbol", symbol, exp_sym);
`ifdef FWD_PRE_ZBLK_EN
    checkOutput("zero_blk", zero_blk, exp_zero);
`endif
  endtask

  // Keeps out_ready low for n cycles (with stray starts), then hands off
  task automatic holdRelease(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'b0;
      start     = 1'($urandom_range(0, 1));
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_symbol", symbol, exp_sym);
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_out_valid", out_valid, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_symbol", symbol, 0);
`ifdef FWD_PRE_ZBLK_EN
    checkOutput("reset_zero_blk", zero_blk, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Small deltas inside theta
    smp[0] = 502; smp[1] = 498;
    applyStimulus(2, 500, 1'b0, 1'b0, -1);
    checkOutput("r030_slot0", symbol[SW-1 -: DW], 4);
    checkOutput("r030_slot1", symbol[SW-1-DW -: DW], 7);
    checkOutput("r030_rest", symbol[SW-1-2*DW:0], 0);
    holdRelease(2);

    // delta equal to theta, and beyond theta in both directions
    smp[0] = 20; smp[1] = 900;
    applyStimulus(2, 10, 1'b0, 1'b0, -1);
    checkOutput("r031_slot0", symbol[SW-1 -: DW], 20);
    checkOutput("r031_slot1", symbol[SW-1-DW -: DW], 900);
    holdRelease(0);
    smp[0] = 5;
    applyStimulus(1, 1000, 1'b0, 1'b0, -1);
    checkOutput("r031_slot0_far", symbol[SW-1 -: DW], 1018);
    holdRelease(1);

    // j = 0 means a full block, held through a long stall
    fillRandom(BLKMAX);
    applyStimulus(0, $urandom_range(0, MAXV), 1'b0, 1'b0, -1);
    holdRelease(5);

    // Gapped input with a stray start in RUN, then a back-to-back block
    fillRandom(4);
    applyStimulus(4, $urandom_range(0, MAXV), 1'b1, 1'b1, -1);
    holdRelease(1);
    fillRandom(3);
    applyStimulus(3, $urandom_range(0, MAXV), 1'b0, 1'b0, -1);
    holdRelease(0);

    // Reset in the middle of a block
    fillRandom(8);
    applyStimulus(8, $urandom_range(0, MAXV), 1'b0, 1'b0, 3);
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_symbol", symbol, 0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postrst_out_valid", out_valid, 0);
    end
    smp[0] = 7;
    applyStimulus(1, 7, 1'b0, 1'b0, -1);
    checkOutput("r033_slot0", symbol[SW-1 -: DW], 0);
`ifdef FWD_PRE_ZBLK_EN
    checkOutput("r033_zero_blk", zero_blk, 1);
`endif
    holdRelease(1);

    // Randomized blocks, including lengths beyond the buffer size
    for (int b = 0; b < 12; b++) begin
      fillRandom(BLKMAX);
      applyStimulus($urandom_range(0, 63), $urandom_range(0, MAXV),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      holdRelease($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
